rx_link_sync_20b16b: RTL and testbench

- Word-alignment and link-synchronisation controller for the receive path behind the 20B/16B dual-byte decoder.
- Monitors the decoder's registered outputs (16-bit data, per-byte K flag, code error, disparity error) and hunts for the comma byte in the upper byte lane.
- Pulses a bitslip request to the upstream 20-bit deserialiser/gearbox until the comma is aligned, then declares lock with error hysteresis.
- Forwards decoded words downstream only while locked.

---
 rtl/rx_link_sync_20b16b.sv | 239 +++++++++++++++++++++++
 tb/tb_rx_link_sync_20b16b.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_link_sync_20b16b.sv
// ---------------------------------------------------------------------------
// rx_link_sync_20b16b
//
// Word-alignment and link-synchronisation controller for the receive path
// behind the 20B/16B dual-byte decoder. It watches the decoded words for the
// comma byte in the upper lane and asks the deserialiser to slip one bit at a
// time until the comma lands there. After enough aligned commas it declares
// lock, keeps it with error hysteresis, and forwards words downstream only
// while locked.
//
// Ports
//   clk             rx clock, all logic on the rising edge
//   rst             synchronous reset, active low
//   in_valid        dec_* hold a new decoded word this cycle
//   dec_data[15:0]  decoded word; [15:8] is lane 0 (first received)
//   dec_ko[1:0]     K flag; bit0 -> dec_data[15:8], bit1 -> dec_data[7:0]
//   dec_code_err    illegal-code flag per lane (same bit mapping)
//   dec_disp_err    disparity-error flag per lane (same bit mapping)
//   bitslip         one-cycle pulse: shift the 20-bit boundary by one bit
//   link_up         high while LOCKED
//   sync_state      0=HUNT, 1=ACQ, 2=LOCKED, 3=SLIP
//   rx_valid        rx_data/rx_ko carry a forwarded word
//   rx_data[15:0]   forwarded word (holds when rx_valid is low)
//   rx_ko[1:0]      forwarded K flags
//   slip_count      bitslip pulses issued, wraps 255 -> 0
//   bad_word_count  bad words seen outside SLIP, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module rx_link_sync_20b16b #(
    parameter logic [7:0]  COMMA_BYTE     = 8'hBC,
    parameter int unsigned ACQ_COUNT      = 4,
    parameter int unsigned ERR_LIMIT      = 4,
    parameter int unsigned GOOD_RUN       = 4,
    parameter int unsigned SEARCH_TIMEOUT = 64,
    parameter int unsigned SLIP_WAIT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] dec_data,
    input  logic [1:0]  dec_ko,
    input  logic [1:0]  dec_code_err,
    input  logic [1:0]  dec_disp_err,
    output logic        bitslip,
    output logic        link_up,
    output logic [1:0]  sync_state,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    output logic [1:0]  rx_ko,
    output logic [7:0]  slip_count,
    output logic [15:0] bad_word_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_SLIP   = 2'd3
    } state_t;

    localparam logic [3:0] ACQ_N     = 4'(ACQ_COUNT);
    localparam logic [3:0] ERR_N     = 4'(ERR_LIMIT);
    localparam logic [7:0] GOOD_N    = 8'(GOOD_RUN);
    localparam logic [9:0] TIMEOUT_N = 10'(SEARCH_TIMEOUT);
    localparam logic [7:0] WAIT_N    = 8'(SLIP_WAIT);

    state_t      state_q, state_d;
    logic [9:0]  search_q, search_d;
    logic [3:0]  acq_q, acq_d;
    logic [3:0]  err_q, err_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  wait_q, wait_d;
    logic        bitslip_q, bitslip_d;
    logic        link_up_q, link_up_d;
    logic [7:0]  slip_count_q, slip_count_d;
    logic [15:0] bad_q, bad_d;
    logic        rx_valid_q, rx_valid_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic [1:0]  rx_ko_q, rx_ko_d;

    logic        word_bad;
    logic        word_comma;
    logic        enter_slip;
    logic [9:0]  search_inc;
    logic [3:0]  acq_next;
    logic [3:0]  err_inc;
    logic [7:0]  good_inc;

    // Errors win over the comma test: a comma with any error flag is bad.
    // Only lane 0 can carry the alignment comma.
    always_comb begin
        word_bad   = (|dec_code_err) || (|dec_disp_err);
        word_comma = !word_bad && dec_ko[0] && (dec_data[15:8] == COMMA_BYTE);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        search_d     = search_q;
        acq_d        = acq_q;
        err_d        = err_q;
        good_d       = good_q;
        wait_d       = wait_q;
        bitslip_d    = 1'b0;
        slip_count_d = slip_count_q;
        bad_d        = bad_q;
        enter_slip   = 1'b0;
        search_inc   = search_q + 10'd1;
        acq_next     = (state_q == ST_HUNT) ? 4'd1 : acq_q + 4'd1;
        err_inc      = err_q + 4'd1;
        good_inc     = good_q + 8'd1;

        unique case (state_q)
            ST_HUNT, ST_ACQ: begin
                if (in_valid) begin
                    if (word_bad && (state_q == ST_ACQ)) begin
                        state_d  = ST_HUNT;
                        search_d = '0;
                    end else if (word_comma) begin
                        search_d = '0;
                        acq_d    = acq_next;
                        if (acq_next == ACQ_N) begin
                            state_d = ST_LOCKED;
                            err_d   = '0;
                            good_d  = '0;
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end else begin
                        // Every valid non-comma word, bad or good, counts
                        // toward the search timeout.
                        search_d = search_inc;
                        if (search_inc == TIMEOUT_N) begin
                            enter_slip = 1'b1;
                        end
                    end
                end
            end

            ST_LOCKED: begin
                if (in_valid) begin
                    search_d = '0;
                    if (word_bad) begin
                        good_d = '0;
                        err_d  = err_inc;
                        if (err_inc == ERR_N) begin
                            state_d = ST_HUNT;
                        end
                    end else if (good_inc == GOOD_N) begin
                        // A full run of good words forgives one error.
                        good_d = '0;
                        if (err_q != 4'd0) begin
                            err_d = err_q - 4'd1;
                        end
                    end else begin
                        good_d = good_inc;
                    end
                end
            end

            ST_SLIP: begin
                // wait_q counts the blanking cycles after the pulse cycle;
                // inputs are ignored throughout.
                if (wait_q == WAIT_N) begin
                    state_d  = ST_HUNT;
                    search_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: state_d = ST_HUNT;
        endcase

        if (enter_slip) begin
            state_d      = ST_SLIP;
            wait_d       = '0;
            bitslip_d    = 1'b1;
            slip_count_d = slip_count_q + 8'd1;
        end

        if (in_valid && word_bad && (state_q != ST_SLIP) && (bad_q != 16'hFFFF)) begin
            bad_d = bad_q + 16'd1;
        end
    end

    // Forwarding looks at the state before the edge, so the word that drops
    // lock is still delivered.
    always_comb begin
        link_up_d  = (state_d == ST_LOCKED);
        rx_valid_d = in_valid && (state_q == ST_LOCKED);
        rx_data_d  = rx_valid_d ? dec_data : rx_data_q;
        rx_ko_d    = rx_valid_d ? dec_ko   : rx_ko_q;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_HUNT;
            search_q     <= '0;
            acq_q        <= '0;
            err_q        <= '0;
            good_q       <= '0;
            wait_q       <= '0;
            bitslip_q    <= 1'b0;
            link_up_q    <= 1'b0;
            slip_count_q <= '0;
            bad_q        <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_ko_q      <= '0;
        end else begin
            state_q      <= state_d;
            search_q     <= search_d;
            acq_q        <= acq_d;
            err_q        <= err_d;
            good_q       <= good_d;
            wait_q       <= wait_d;
            bitslip_q    <= bitslip_d;
            link_up_q    <= link_up_d;
            slip_count_q <= slip_count_d;
            bad_q        <= bad_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_ko_q      <= rx_ko_d;
        end
    end

    assign bitslip        = bitslip_q;
    assign link_up        = link_up_q;
    assign sync_state     = state_q;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;
    assign rx_ko          = rx_ko_q;
    assign slip_count     = slip_count_q;
    assign bad_word_count = bad_q;

endmodule

// File: tb/tb_rx_link_sync_20b16b.sv
// ---------------------------------------------------------------------------
// tb_rx_link_sync_20b16b
//
// Bench for rx_link_sync_20b16b. A behavioural reference model tracks the
// link state with plain integers (a countdown for the slip blanking window)
// and predicts every output after each clock edge. Directed scenario tasks
// are followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_rx_link_sync_20b16b;

    localparam int ACQ_COUNT      = 4;
    localparam int ERR_LIMIT      = 4;
    localparam int GOOD_RUN       = 4;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int SLIP_WAIT      = 16;
    localparam logic [7:0] COMMA  = 8'hBC;

    localparam int S_HUNT = 0, S_ACQ = 1, S_LOCKED = 2, S_SLIP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] dec_data = '0;
    logic [1:0]  dec_ko = '0;
    logic [1:0]  dec_code_err = '0;
    logic [1:0]  dec_disp_err = '0;
    logic        bitslip;
    logic        link_up;
    logic [1:0]  sync_state;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [1:0]  rx_ko;
    logic [7:0]  slip_count;
    logic [15:0] bad_word_count;

    rx_link_sync_20b16b #(
        .COMMA_BYTE     (COMMA),
        .ACQ_COUNT      (ACQ_COUNT),
        .ERR_LIMIT      (ERR_LIMIT),
        .GOOD_RUN       (GOOD_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .dec_data       (dec_data),
        .dec_ko         (dec_ko),
        .dec_code_err   (dec_code_err),
        .dec_disp_err   (dec_disp_err),
        .bitslip        (bitslip),
        .link_up        (link_up),
        .sync_state     (sync_state),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ko          (rx_ko),
        .slip_count     (slip_count),
        .bad_word_count (bad_word_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_state = S_HUNT;
    int          m_acq = 0;
    int          m_err = 0;
    int          m_good = 0;
    int          m_search = 0;
    int          m_slip_left = 0;
    int          m_slip_cnt = 0;
    int          m_bad_cnt = 0;
    logic        m_bitslip = 1'b0;
    logic        m_rx_valid = 1'b0;
    logic [15:0] m_rx_data = '0;
    logic [1:0]  m_rx_ko = '0;

    logic [46:0] dut_obs;
    assign dut_obs = {bitslip, link_up, sync_state, rx_valid, rx_data, rx_ko,
                      slip_count, bad_word_count};

    function automatic logic [46:0] expect_obs();
        logic lu;
        lu = (m_state == S_LOCKED);
        return {m_bitslip, lu, 2'(m_state), m_rx_valid, m_rx_data, m_rx_ko,
                8'(m_slip_cnt), 16'(m_bad_cnt)};
    endfunction

    task automatic model_enter_slip();
        m_state     = S_SLIP;
        m_bitslip   = 1'b1;
        m_slip_cnt  = (m_slip_cnt + 1) % 256;
        m_slip_left = SLIP_WAIT;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        logic bad;
        logic comma;
        if (!rst) begin
            m_state = S_HUNT; m_acq = 0; m_err = 0; m_good = 0; m_search = 0;
            m_slip_left = 0; m_slip_cnt = 0; m_bad_cnt = 0;
            m_bitslip = 1'b0; m_rx_valid = 1'b0; m_rx_data = '0; m_rx_ko = '0;
            return;
        end
        m_bitslip  = 1'b0;
        m_rx_valid = (m_state == S_LOCKED) && in_valid;
        if (m_rx_valid) begin
            m_rx_data = dec_data;
            m_rx_ko   = dec_ko;
        end
        if (m_state == S_SLIP) begin
            if (m_slip_left == 0) begin
                m_state  = S_HUNT;
                m_search = 0;
            end else begin
                m_slip_left--;
            end
            return;
        end
        if (!in_valid) return;
        bad   = (dec_code_err != 2'b00) || (dec_disp_err != 2'b00);
        comma = !bad && dec_ko[0] && (dec_data[15:8] == COMMA);
        if (bad && m_bad_cnt < 65535) m_bad_cnt++;
        if (m_state == S_LOCKED) begin
            if (bad) begin
                m_err++;
                m_good = 0;
                if (m_err >= ERR_LIMIT) begin
                    m_state  = S_HUNT;
                    m_search = 0;
                end
            end else begin
                m_good++;
                if (m_good >= GOOD_RUN) begin
                    m_good = 0;
                    if (m_err > 0) m_err--;
                end
            end
        end else if (m_state == S_ACQ && bad) begin
            m_state  = S_HUNT;
            m_search = 0;
        end else if (comma) begin
            m_search = 0;
            m_acq    = (m_state == S_HUNT) ? 1 : m_acq + 1;
            if (m_acq >= ACQ_COUNT) begin
                m_state = S_LOCKED;
                m_err   = 0;
                m_good  = 0;
            end else begin
                m_state = S_ACQ;
            end
        end else begin
            m_search++;
            if (m_search >= SEARCH_TIMEOUT) model_enter_slip();
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle.
    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] ko,
                        input logic [1:0] ce, input logic [1:0] de);
        in_valid     = v;
        dec_data     = d;
        dec_ko       = ko;
        dec_code_err = ce;
        dec_disp_err = de;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step_comma();
        step(1'b1, {COMMA, 8'h50}, 2'b01, 2'b00, 2'b00);
    endtask

    // Random error-free word that is guaranteed not to be an upper-lane comma.
    task automatic step_good(output logic [15:0] d);
        logic [1:0] ko;
        d  = 16'($urandom);
        ko = 2'($urandom);
        if (ko[0] && d[15:8] == COMMA) d[15:8] = 8'h3C;
        step(1'b1, d, ko, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, '0, '0, '0, '0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst = 1'b0;
            step(1'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            n_vec++;
            if (dut_obs !== 47'd0) begin
                n_err++;
                $display("FAIL reset_c%0d obs=%h required=0", i, dut_obs);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_acquisition();
        logic [15:0] d;
        for (int i = 0; i < ACQ_COUNT; i++) begin
            step_comma();
            n_vec++;
            if (dut_obs !== expect_obs()) begin
                n_err++;
                $display("FAIL acq_word%0d obs=%h expected=%h", i, dut_obs, expect_obs());
            end
        end
        n_vec++;
        if (sync_state !== 2'd2 || link_up !== 1'b1 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL acq_locked state=%0d link_up=%0b rx_valid=%0b expected 2/1/0",
                     sync_state, link_up, rx_valid);
        end
        step_good(d);
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== d) begin
            n_err++;
            $display("FAIL acq_forward rx_valid=%0b rx_data=%h expected 1/%h", rx_valid, rx_data, d);
        end
    endtask

    // Starts locked with err=0. Three bad words, four good words (err 3 -> 2),
    // then one bad keeps the link (err 3) and the next drops it (err 4).
    task automatic test_hysteresis();
        logic [15:0] d;
        for (int i = 0; i < 9; i++) begin
            if (i < 3 || i >= 7) step(1'b1, 16'($urandom), 2'b00, 2'b00, 2'b10);
            else step_good(d);
            n_vec++;
            if (link_up !== (i < 8) || dut_obs !== expect_obs()) begin
                n_err++;
                $display("FAIL hyst_word%0d link_up=%0b obs=%h expected=%h",
                         i, link_up, dut_obs, expect_obs());
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < ACQ_COUNT; i++) step_comma();
        for (int i = 0; i < ERR_LIMIT; i++) begin
            d = 16'($urandom);
            step(1'b1, d, 2'b00, 2'b00, 2'b10);
        end
        n_vec++;
        if (link_up !== 1'b0 || sync_state !== 2'd0 || bad_word_count !== 16'd4 ||
            rx_valid !== 1'b1 || rx_data !== d) begin
            n_err++;
            $display("FAIL lock_loss link=%0b state=%0d bad=%0d rxv=%0b rxd=%h expected 0/0/4/1/%h",
                     link_up, sync_state, bad_word_count, rx_valid, rx_data, d);
        end
    endtask

    task automatic test_slip();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < SEARCH_TIMEOUT; i++) begin
            step_good(d);
            n_vec++;
            if (dut_obs !== expect_obs()) begin
                n_err++;
                $display("FAIL slip_search%0d obs=%h expected=%h", i, dut_obs, expect_obs());
            end
        end
        n_vec++;
        if (sync_state !== 2'd3 || bitslip !== 1'b1 || slip_count !== 8'd1) begin
            n_err++;
            $display("FAIL slip_pulse state=%0d bitslip=%0b slips=%0d expected 3/1/1",
                     sync_state, bitslip, slip_count);
        end
        for (int i = 0; i < SLIP_WAIT; i++) begin
            step(1'b1, {COMMA, 8'($urandom)}, 2'b01, 2'($urandom), 2'b01);
            n_vec++;
            if (sync_state !== 2'd3 || bitslip !== 1'b0 || bad_word_count !== 16'd0 ||
                rx_valid !== 1'b0) begin
                n_err++;
                $display("FAIL slip_wait%0d state=%0d bitslip=%0b bad=%0d rxv=%0b expected 3/0/0/0",
                         i, sync_state, bitslip, bad_word_count, rx_valid);
            end
        end
        step_good(d);
        n_vec++;
        if (sync_state !== 2'd0 || slip_count !== 8'd1 || bitslip !== 1'b0) begin
            n_err++;
            $display("FAIL slip_exit state=%0d slips=%0d bitslip=%0b expected 0/1/0",
                     sync_state, slip_count, bitslip);
        end
    endtask

    task automatic test_priority();
        do_reset();
        step_comma();
        n_vec++;
        if (sync_state !== 2'd1) begin
            n_err++;
            $display("FAIL prio_acq state=%0d expected 1", sync_state);
        end
        step(1'b1, {COMMA, 8'h50}, 2'b01, 2'b01, 2'b00);
        n_vec++;
        if (sync_state !== 2'd0 || bad_word_count !== 16'd1) begin
            n_err++;
            $display("FAIL prio_bad_comma state=%0d bad=%0d expected 0/1", sync_state, bad_word_count);
        end
    endtask

    task automatic test_lower_lane_comma();
        do_reset();
        for (int i = 0; i < SEARCH_TIMEOUT; i++) begin
            step(1'b1, 16'h50BC, 2'b10, 2'b00, 2'b00);
            n_vec++;
            if (sync_state !== ((i == SEARCH_TIMEOUT - 1) ? 2'd3 : 2'd0)) begin
                n_err++;
                $display("FAIL lower_lane%0d state=%0d expected %0d",
                         i, sync_state, (i == SEARCH_TIMEOUT - 1) ? 3 : 0);
            end
        end
    endtask

    // Continues from the first SLIP cycle left by the lower-lane test.
    task automatic test_reset_mid_slip();
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0);
        n_vec++;
        if (sync_state !== 2'd3 || slip_count !== 8'd1) begin
            n_err++;
            $display("FAIL midslip_pre state=%0d slips=%0d expected 3/1", sync_state, slip_count);
        end
        rst = 1'b0;
        step(1'b1, 16'($urandom), 2'($urandom), 2'b00, 2'b00);
        rst = 1'b1;
        n_vec++;
        if (sync_state !== 2'd0 || slip_count !== 8'd0 || bitslip !== 1'b0) begin
            n_err++;
            $display("FAIL midslip_reset state=%0d slips=%0d bitslip=%0b expected 0/0/0",
                     sync_state, slip_count, bitslip);
        end
    endtask

    // Phases vary comma density so timeouts, acquisition and lock all occur.
    task automatic test_random();
        int comma_pct [4] = '{0, 40, 6, 30};
        logic [15:0] d;
        logic [1:0]  ko, ce, de;
        logic        v;
        int          r;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1000; i++) begin
                rst = ($urandom_range(0, 299) != 0);
                v   = ($urandom_range(0, 99) < 85);
                r   = $urandom_range(0, 99);
                d   = 16'($urandom);
                ko  = 2'($urandom);
                ce  = 2'b00;
                de  = 2'b00;
                if (r < comma_pct[p]) begin
                    d[15:8] = COMMA;
                    ko[0]   = 1'b1;
                end else if (r < comma_pct[p] + 8) begin
                    ce = 2'($urandom);
                    de = 2'($urandom);
                    if (ce == 2'b00 && de == 2'b00) de = 2'b01;
                end
                step(v, d, ko, ce, de);
                n_vec++;
                if (dut_obs !== expect_obs()) begin
                    n_err++;
                    $display("FAIL random_p%0d_c%0d obs=%h expected=%h", p, i, dut_obs, expect_obs());
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_hysteresis();
        test_loss_of_lock();
        test_slip();
        test_priority();
        test_lower_lane_comma();
        test_reset_mid_slip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
